// File: rtl/frame_pkg.sv
// Shared constants and state encoding for the frame payload extractor.
package frame_pkg;

  localparam logic [7:0] FRAMEHEAD  = 8'h47;
  localparam int         FRAMECOUNT = 10;
  localparam int         PAYLOAD    = FRAMECOUNT - 1;
  localparam int         IDX_W      = $clog2(PAYLOAD + 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b001,
    ST_COLLECT = 3'b010,
    ST_DROP    = 3'b100
  } state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/frame_buf.sv
// Payload byte store: tentative writes become visible only on commit; FWFT read side
// tracks the byte position inside each frame for start/end markers.
module frame_buf
  import frame_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en_i,
  input  logic [7:0]                wr_data_i,
  input  logic                      commit_i,
  input  logic                      rewind_i,
  input  logic                      rd_en_i,
  output logic [7:0]                rd_data_o,
  output logic                      empty_o,
  output logic [$clog2(DEPTH):0]    free_o,
  output logic                      rd_sof_o,
  output logic                      rd_eof_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wr_tmp_q, wr_commit_q, rd_ptr_q;
  logic [IDX_W-1:0] rd_idx_q;
  logic [7:0]       mem_q [DEPTH];
  logic [PW-1:0]    commit_eff_s;
  logic [PW-1:0]    used_s;
  logic             rd_fire_s;

  // A same-cycle commit already counts against free space, so the next frame's
  // start decision sees the buffer as it will be after this edge.
  assign commit_eff_s = commit_i ? wr_tmp_q : wr_commit_q;
  assign used_s       = commit_eff_s - rd_ptr_q;
  assign free_o       = PW'(DEPTH) - used_s;
  assign empty_o      = (rd_ptr_q == wr_commit_q);
  assign rd_fire_s    = rd_en_i && !empty_o;
  assign rd_data_o    = mem_q[rd_ptr_q[AW-1:0]];
  assign rd_sof_o     = !empty_o && (rd_idx_q == IDX_W'(0));
  assign rd_eof_o     = !empty_o && (rd_idx_q == IDX_W'(PAYLOAD - 1));

  // Pointer and frame-position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_tmp_q    <= '0;
      wr_commit_q <= '0;
      rd_ptr_q    <= '0;
      rd_idx_q    <= '0;
    end else begin
      if (commit_i) begin
        wr_commit_q <= wr_tmp_q;
      end
      if (rewind_i) begin
        wr_tmp_q <= wr_commit_q;
      end else if (wr_en_i) begin
        wr_tmp_q <= wr_tmp_q + PW'(1);
      end
      if (rd_fire_s) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
        if (rd_idx_q == IDX_W'(PAYLOAD - 1)) begin
          rd_idx_q <= '0;
        end else begin
          rd_idx_q <= rd_idx_q + IDX_W'(1);
        end
      end
    end
  end

  // Byte storage write port.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_tmp_q[AW-1:0]] <= wr_data_i;
    end
  end

endmodule

// File: rtl/frame_payload_extract.sv
// Collects the payload bytes between frame heads, commits a frame only when the next
// sync arrives exactly on time, and streams committed payload out with sof/eof.
module frame_payload_extract
  import frame_pkg::*;
#(
  parameter int DEPTH      = 32,
  parameter bit CHECK_HEAD = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       syn_flag,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sof,
  output logic       out_eof,
  output logic [7:0] drop_cnt
);

  localparam int PW = $clog2(DEPTH) + 1;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       drop_q, drop_d;
  logic             buf_wr_s, buf_commit_s, buf_rewind_s;
  logic             drop_ev_s, start_s, accept_s, head_ok_s, empty_s;
  logic [PW-1:0]    free_s;

  frame_buf #(.DEPTH(DEPTH)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (buf_wr_s),
    .wr_data_i (data),
    .commit_i  (buf_commit_s),
    .rewind_i  (buf_rewind_s),
    .rd_en_i   (out_ready),
    .rd_data_o (out_data),
    .empty_o   (empty_s),
    .free_o    (free_s),
    .rd_sof_o  (out_sof),
    .rd_eof_o  (out_eof)
  );

  assign head_ok_s = !CHECK_HEAD || (data == FRAMEHEAD);
  assign accept_s  = head_ok_s && (free_s >= PW'(PAYLOAD));
  assign out_valid = !empty_s;
  assign drop_cnt  = drop_q;

  // Next-state logic; a premature abort followed by a rejected start is one drop event.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    buf_wr_s     = 1'b0;
    buf_commit_s = 1'b0;
    buf_rewind_s = 1'b0;
    drop_ev_s    = 1'b0;
    start_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (syn_flag) begin
          start_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (idx_q < IDX_W'(PAYLOAD)) begin
          if (syn_flag) begin
            buf_rewind_s = 1'b1;
            drop_ev_s    = 1'b1;
            start_s      = 1'b1;
          end else begin
            buf_wr_s = 1'b1;
            idx_d    = idx_q + IDX_W'(1);
          end
        end else if (syn_flag) begin
          buf_commit_s = 1'b1;
          start_s      = 1'b1;
        end else begin
          buf_rewind_s = 1'b1;
          drop_ev_s    = 1'b1;
          state_d      = ST_IDLE;
          idx_d        = '0;
        end
      end
      ST_DROP: begin
        if (syn_flag) begin
          start_s = 1'b1;
        end else if (idx_q < IDX_W'(PAYLOAD)) begin
          idx_d = idx_q + IDX_W'(1);
        end else begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
    if (start_s) begin
      idx_d = '0;
      if (accept_s) begin
        state_d = ST_COLLECT;
      end else begin
        state_d   = ST_DROP;
        drop_ev_s = 1'b1;
      end
    end else begin
      idx_d = idx_d;
    end
    if (drop_ev_s) begin
      drop_d = sat_inc8(drop_q);
    end else begin
      drop_d = drop_q;
    end
  end

  // FSM, byte index and drop counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      drop_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drop_q  <= drop_d;
    end
  end

endmodule
